io_button_reader: RTL and testbench
===================================

IO_BUTTON_READER -- requirements
Module: io_button_reader

Interface
REQ-001 Parameter N_BTN, default 4: number of button input pads, 1..8.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000: stable-sample count needed to accept a level change, 2..65535.
REQ-003 Parameter BASE_ADDR, default 32'h3000_0000: Wishbone base address, decoded on wbs_adr_i[31:8].
REQ-004 clk  input  1  single clock, driven from wb_clk_i.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 btn_in  input  N_BTN  raw button pad levels (io_in slice), asynchronous to clk.
REQ-007 btn_oeb  output  N_BTN  pad output-enable bar; held all-ones so the pads act as inputs.
REQ-008 wbs_stb_i, wbs_cyc_i, wbs_we_i  input  1 each  Wishbone classic strobe, cycle and write-enable.
REQ-009 wbs_sel_i  input  4  byte selects; ignored, every access is a full 32-bit word.
REQ-010 wbs_adr_i, wbs_dat_i  input  32 each  address and write data.
REQ-011 wbs_ack_o  output  1  transfer acknowledge.
REQ-012 wbs_dat_o  output  32  read data.
REQ-013 irq  output  1  level interrupt to user_irq.

Function
REQ-014 Each btn_in bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-015 Per channel, a 16-bit debounce counter SHALL increment every cycle that the synced level differs from the stable level, and SHALL clear on any cycle where they match.
REQ-016 When the counter equals DEBOUNCE_CYCLES-1 and the levels still differ, the stable level SHALL take the synced value and the counter SHALL clear. Pin-to-stable latency is exactly 2+DEBOUNCE_CYCLES cycles.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES synced cycles SHALL NOT change the stable level.
REQ-018 A 0->1 stable transition is a press event. It SHALL set PENDING[i] and increment COUNT[i], a 16-bit counter that saturates at 16'hFFFF.
REQ-019 Register map, word offsets from BASE_ADDR:
- 0x00 STATUS (RO): stable levels in bits [N_BTN-1:0].
- 0x04 PENDING (W1C).
- 0x08 IRQ_EN (RW), bits [N_BTN-1:0].
- 0x10+4*i COUNT[i] (RO in bits [15:0]; any write clears it).
REQ-020 Unused register bits SHALL read 0. Unmapped offsets inside the 256-byte window SHALL read 0, ignore writes and still ack.
REQ-021 A request is wbs_stb_i & wbs_cyc_i with wbs_adr_i[31:8] == BASE_ADDR[31:8].
- wbs_ack_o SHALL assert for exactly one cycle, on the cycle after the request is seen, with wbs_dat_o valid in that same cycle.
- No new request is accepted while wbs_ack_o is high.
REQ-022 wbs_dat_o SHALL be 0 whenever wbs_ack_o is low.
REQ-023 Simultaneous press event and W1C on the same PENDING bit: the set SHALL win.
REQ-024 Simultaneous press event and COUNT[i] write: COUNT[i] SHALL become 1.
REQ-025 irq SHALL be registered and equal to |(PENDING & IRQ_EN), one cycle after either term changes.

Reset
REQ-026 On reset_n low, the following SHALL clear asynchronously to 0: synchronizers, stable levels, debounce counters, PENDING, IRQ_EN, COUNT[*], wbs_ack_o, wbs_dat_o and irq. btn_oeb SHALL read all-ones.
REQ-027 A reset asserted mid-transfer SHALL drop any pending ack. After release, the first edge SHALL sample btn_in with no press events generated from the reset state.

Structure
REQ-028 Package io_button_pkg SHALL hold the register offset constants, the COUNT width (16) and the debounce counter width (16).
REQ-029 Sub-module btn_debounce SHALL implement one channel's synchronizer, debounce counter and press-event pulse, instantiated N_BTN times.

Verification (DEBOUNCE_CYCLES=8, N_BTN=4)
REQ-030 Drive btn_in[0] 0->1 and hold -> STATUS[0]=1 exactly 10 cycles later; PENDING=0x1; COUNT[0]=1.
REQ-031 Pulse btn_in[1] high for 5 cycles -> STATUS, PENDING and COUNT[1] stay 0.
REQ-032 Write IRQ_EN=0x4, then press btn 2 -> irq=1; write PENDING=0x4 -> irq=0 within 2 cycles.
REQ-033 Issue a W1C to PENDING[3] on the same cycle as a btn 3 press event -> PENDING[3] stays 1.
REQ-034 Generate 65537 presses on btn 0 -> COUNT[0]=0xFFFF. Write 0x10 -> COUNT[0] reads 0.
REQ-035 Read offset 0x3C and an address outside the window -> 0x3C acks once with data 0; the outside address gets no ack.

Source files
------------

// File: rtl/io_button_pkg.sv
// Shared constants for the button reader: register offsets and counter widths.
package io_button_pkg;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned DB_W  = 16;

    localparam logic [7:0] OFS_STATUS  = 8'h00;
    localparam logic [7:0] OFS_PENDING = 8'h04;
    localparam logic [7:0] OFS_IRQ_EN  = 8'h08;
    localparam logic [7:0] OFS_COUNT0  = 8'h10;

    function automatic logic [7:0] count_ofs(input int unsigned idx);
        return OFS_COUNT0 + 8'(idx << 2);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, debounce counter and press pulse.
module btn_debounce
    import io_button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pad,
    output logic level,
    output logic press
);

    localparam logic [DB_W-1:0] LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync_a;
    logic            sync_b;
    logic [DB_W-1:0] cnt;
    logic            accept;

    // press is combinational so PENDING/COUNT update on the same edge as level
    assign accept = (sync_b != level) && (cnt == LAST);
    assign press  = accept && sync_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_a <= pad;
            sync_b <= sync_a;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= sync_b;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_button_reader.sv
// Debounced button inputs with press counters, pending flags and a Wishbone slave.
module io_button_reader
    import io_button_pkg::*;
#(
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter logic [31:0] BASE_ADDR       = 32'h3000_0000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_oeb,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic             irq
);

    logic [N_BTN-1:0]            level;
    logic [N_BTN-1:0]            press;
    logic [N_BTN-1:0]            pending;
    logic [N_BTN-1:0]            irq_en;
    logic [N_BTN-1:0][CNT_W-1:0] counts;
    logic [N_BTN-1:0]            w1c;
    logic [N_BTN-1:0]            cnt_clr;
    logic [7:0]                  ofs;
    logic [31:0]                 rdata;
    logic                        req;
    logic                        wr;
    logic                        unused_bits;

    assign btn_oeb     = '1;
    assign unused_bits = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i};

    for (genvar g = 0; g < N_BTN; g++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .reset_n(reset_n),
            .pad    (btn_in[g]),
            .level  (level[g]),
            .press  (press[g])
        );
    end

    // A request is refused while ack is high so each access acks exactly once
    assign ofs = {wbs_adr_i[7:2], 2'b00};
    assign req = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~wbs_ack_o;
    assign wr  = req & wbs_we_i;

    always_comb begin
        rdata   = '0;
        w1c     = '0;
        cnt_clr = '0;
        if (ofs == OFS_STATUS) begin
            rdata[N_BTN-1:0] = level;
        end else if (ofs == OFS_PENDING) begin
            rdata[N_BTN-1:0] = pending;
            if (wr) w1c = wbs_dat_i[N_BTN-1:0];
        end else if (ofs == OFS_IRQ_EN) begin
            rdata[N_BTN-1:0] = irq_en;
        end
        for (int unsigned i = 0; i < N_BTN; i++) begin
            if (ofs == count_ofs(i)) begin
                rdata[CNT_W-1:0] = counts[i];
                cnt_clr[i]       = wr;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            pending   <= '0;
            irq_en    <= '0;
            counts    <= '0;
            irq       <= 1'b0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= req ? rdata : '0;
            if (wr && ofs == OFS_IRQ_EN) irq_en <= wbs_dat_i[N_BTN-1:0];
            pending <= (pending & ~w1c) | press;
            irq     <= |(pending & irq_en);
            for (int unsigned i = 0; i < N_BTN; i++) begin
                if (cnt_clr[i]) begin
                    counts[i] <= press[i] ? CNT_W'(1) : '0;
                end else if (press[i] && counts[i] != '1) begin
                    counts[i] <= counts[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_io_button_reader.sv
// Randomized scoreboard bench for io_button_reader with an abstract button/register model.
module tb_io_button_reader;

    localparam int unsigned N = 4;
    localparam int unsigned D = 8;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  btn_in;
    logic [N-1:0]  btn_oeb;
    logic          wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]    wbs_sel_i;
    logic [31:0]   wbs_adr_i, wbs_dat_i;
    logic          wbs_ack_o;
    logic [31:0]   wbs_dat_o;
    logic          irq;

    always #5 clk = ~clk;

    io_button_reader #(
        .N_BTN(N),
        .DEBOUNCE_CYCLES(D),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .reset_n(reset_n), .btn_in(btn_in), .btn_oeb(btn_oeb),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o), .irq(irq)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [31:0] exp_q[$];

    // Reference model: a level is accepted after D consecutive equal samples
    // seen through a 2-cycle synchronizer delay.
    logic [N-1:0] m_stable, m_pend, m_en;
    logic [15:0]  m_cnt[N];
    logic         m_ack, m_irq;
    logic [N-1:0] hist[$];
    logic         sat_load = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] ofs);
        logic [31:0] v;
        v = '0;
        if (ofs == 8'h00) v[N-1:0] = m_stable;
        else if (ofs == 8'h04) v[N-1:0] = m_pend;
        else if (ofs == 8'h08) v[N-1:0] = m_en;
        else if (ofs >= 8'h10 && ofs < 8'h10 + 8'(4 * N)) v[15:0] = m_cnt[(ofs - 8'h10) >> 2];
        return v;
    endfunction

    always @(posedge clk or negedge reset_n) begin : model_step
        logic         req;
        logic [7:0]   ofs;
        logic [N-1:0] press, flip, w1c, clr;
        logic         same;
        if (!reset_n) begin
            m_stable <= '0;
            m_pend   <= '0;
            m_en     <= '0;
            for (int i = 0; i < N; i++) m_cnt[i] <= '0;
            m_ack    <= 1'b0;
            m_irq    <= 1'b0;
            hist.delete();
            repeat (D + 1) hist.push_back('0);
            exp_q.delete();
        end else begin
            ofs = {wbs_adr_i[7:2], 2'b00};
            req = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:8] == BASE[31:8]) && !m_ack;
            if (req) exp_q.push_back(model_read(ofs));
            for (int ch = 0; ch < N; ch++) begin
                same = 1'b1;
                for (int k = 1; k <= D; k++) if (hist[k][ch] != hist[1][ch]) same = 1'b0;
                flip[ch]  = same && (hist[1][ch] != m_stable[ch]);
                press[ch] = flip[ch] && hist[1][ch];
            end
            w1c = '0;
            clr = '0;
            if (req && wbs_we_i) begin
                if (ofs == 8'h04) w1c = wbs_dat_i[N-1:0];
                if (ofs == 8'h08) m_en <= wbs_dat_i[N-1:0];
                for (int i = 0; i < N; i++) if (ofs == 8'(8'h10 + 4 * i)) clr[i] = 1'b1;
            end
            m_ack    <= req;
            m_irq    <= |(m_pend & m_en);
            m_pend   <= (m_pend & ~w1c) | press;
            m_stable <= m_stable ^ flip;
            for (int i = 0; i < N; i++) begin
                if (clr[i]) m_cnt[i] <= press[i] ? 16'd1 : 16'd0;
                else if (press[i] && m_cnt[i] != 16'hFFFF) m_cnt[i] <= m_cnt[i] + 16'd1;
            end
            if (sat_load) m_cnt[0] <= 16'hFFFD;
            hist.push_front(btn_in);
            void'(hist.pop_back());
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            check("irq", {31'd0, irq}, {31'd0, m_irq});
            check("ack_vs_queue", {31'd0, wbs_ack_o}, {31'd0, exp_q.size() != 0});
            if (wbs_ack_o && exp_q.size() != 0) check("rdata", wbs_dat_o, exp_q.pop_front());
            else if (!wbs_ack_o) begin
                check("dat_idle", wbs_dat_o, 32'd0);
                exp_q.delete();
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            output logic got_ack);
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = 4'($urandom);
        got_ack   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wbs_ack_o) begin
                got_ack = 1'b1;
                break;
            end
        end
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic rd(input logic [7:0] ofs);
        logic a;
        wb_cycle(1'b0, BASE | 32'(ofs), 32'($urandom), a);
    endtask

    task automatic wr(input logic [7:0] ofs, input logic [31:0] dat);
        logic a;
        wb_cycle(1'b1, BASE | 32'(ofs), dat, a);
    endtask

    task automatic press_release(input int ch);
        btn_in[ch] = 1'b1;
        idle(D + 3);
        btn_in[ch] = 1'b0;
        idle(D + 3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1);
    end

    initial begin
        logic        a;
        logic [7:0]  ofs;
        logic [7:0]  ofs_list[11];
        ofs_list = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h3C, 8'hFC};
        btn_in = '0;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        check("reset_ack", {31'd0, wbs_ack_o}, 32'd0);
        check("reset_dat", wbs_dat_o, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("btn_oeb", {28'd0, btn_oeb}, 32'h0000_000F);
        idle(3);
        reset_n = 1'b1;
        foreach (ofs_list[i]) rd(ofs_list[i]);

        // Press btn 0; STATUS polled densely at both cycle parities
        for (int r = 0; r < 2; r++) begin
            btn_in[0] = 1'b1;
            idle(r);
            repeat (7) rd(8'h00);
            rd(8'h04);
            rd(8'h10);
            btn_in[0] = 1'b0;
            idle(D + 4);
            wr(8'h04, 32'h1);
        end

        // Short glitch on btn 1
        btn_in[1] = 1'b1;
        idle(5);
        btn_in[1] = 1'b0;
        rd(8'h00);
        idle(D + 3);
        rd(8'h00); rd(8'h04); rd(8'h14);

        // irq path via btn 2
        wr(8'h08, 32'h4);
        rd(8'h08);
        btn_in[2] = 1'b1;
        idle(D + 4);
        rd(8'h04);
        wr(8'h04, 32'h4);
        idle(3);
        btn_in[2] = 1'b0;
        idle(D + 4);

        // W1C coinciding with btn 3 press event
        btn_in[3] = 1'b1;
        idle(D + 1);
        wr(8'h04, 32'h8);
        rd(8'h04);
        btn_in[3] = 1'b0;
        idle(D + 4);

        // COUNT write coinciding with btn 0 press event
        btn_in[0] = 1'b1;
        idle(D + 1);
        wr(8'h10, 32'h0);
        rd(8'h10);
        btn_in[0] = 1'b0;
        idle(D + 4);

        // Saturation: preload COUNT[0] near the top, then press past it
        force dut.counts = {m_cnt[3], m_cnt[2], m_cnt[1], 16'hFFFD};
        #1 release dut.counts;
        sat_load = 1'b1;
        @(negedge clk);
        sat_load = 1'b0;
        rd(8'h10);
        repeat (3) press_release(0);
        rd(8'h10);
        wr(8'h10, 32'hDEAD_BEEF);
        rd(8'h10);

        // Unmapped offset and out-of-window address
        rd(8'h3C);
        wb_cycle(1'b0, BASE + 32'h100, 32'h0, a);
        check("outside_ack", {31'd0, a}, 32'd0);
        wb_cycle(1'b1, 32'h2000_0008, 32'hF, a);
        check("outside_wr_ack", {31'd0, a}, 32'd0);
        rd(8'h08);

        // Random traffic
        wr(8'h08, 32'hF);
        for (int it = 0; it < 600; it++) begin
            for (int ch = 0; ch < N; ch++)
                if ($urandom_range(0, 5) == 0) btn_in[ch] = ~btn_in[ch];
            case ($urandom_range(0, 3))
                0: rd(ofs_list[$urandom_range(0, 10)]);
                1: begin
                    ofs = ($urandom_range(0, 1) == 0) ? ofs_list[$urandom_range(0, 10)]
                                                      : 8'($urandom_range(0, 63) << 2);
                    wr(ofs, $urandom);
                end
                default: idle($urandom_range(1, 3));
            endcase
        end

        // Reset while an ack is in flight
        btn_in = '0;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = BASE;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_ack", {31'd0, wbs_ack_o}, 32'd0);
        check("midreset_dat", wbs_dat_o, 32'd0);
        check("midreset_irq", {31'd0, irq}, 32'd0);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        idle(2);
        reset_n = 1'b1;
        rd(8'h00); rd(8'h04); rd(8'h08); rd(8'h10);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
